// File: rtl/fee_defs.sv
// Shared definitions for the parking fee calculator: FSM state encodings,
// default billing parameters and the elapsed-time helper.
package fee_defs;

    typedef logic [7:0] stamp_t;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_COUNT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam int DEFAULT_BLOCK = 15;
    localparam int DEFAULT_RATE  = 2;

    // Time stamps wrap at 256, so plain 8-bit subtraction gives the
    // elapsed time even when the exit stamp is numerically smaller.
    function automatic stamp_t elapsed(input stamp_t entry_t, input stamp_t exit_t);
        return exit_t - entry_t;
    endfunction

endpackage

// File: rtl/sat_add8.sv
// Unsigned 8-bit adder that clamps at 255 and flags when it had to clamp.
module sat_add8 (
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] sum,
    output logic       sat
);

    logic [8:0] wide_sum;

    // Add with a carry bit; a carry out means the true sum left 8-bit range.
    always_comb begin
        wide_sum = {1'b0, a} + {1'b0, b};
        sat      = wide_sum[8];
        sum      = wide_sum[8] ? 8'hFF : wide_sum[7:0];
    end

endmodule

// File: rtl/fee_calculator.sv
// Parking fee calculator: loads the elapsed time between two stamps, then
// charges RATE per started BLOCK one block per clock, saturating at 255.
module fee_calculator
    import fee_defs::*;
#(
    parameter int BLOCK = DEFAULT_BLOCK,
    parameter int RATE  = DEFAULT_RATE
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] data_P,
    input  logic [7:0] data_Q,
    input  logic       start,
    input  logic       ack,
    output logic       busy,
    output logic       valid,
    output logic [7:0] duration,
    output logic [7:0] fee,
    output logic       overflow
);

    localparam logic [7:0] BLOCK_W = 8'(BLOCK);
    localparam logic [7:0] RATE_W  = 8'(RATE);

    logic [1:0] state;
    logic [7:0] remaining;
    logic [7:0] fee_sum;
    logic       fee_sat;

    sat_add8 u_sat_add8 (
        .a   (fee),
        .b   (RATE_W),
        .sum (fee_sum),
        .sat (fee_sat)
    );

    // Control FSM: load on start, consume one block per clock, hold the result until ack.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= ST_IDLE;
            remaining <= 8'd0;
            duration  <= 8'd0;
            fee       <= 8'd0;
            overflow  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        duration  <= elapsed(data_P, data_Q);
                        remaining <= elapsed(data_P, data_Q);
                        fee       <= 8'd0;
                        overflow  <= 1'b0;
                        state     <= ST_COUNT;
                    end
                end
                ST_COUNT: begin
                    if (remaining == 8'd0) begin
                        state <= ST_DONE;
                    end else begin
                        fee <= fee_sum;
                        if (fee_sat) begin
                            overflow <= 1'b1;
                        end
                        remaining <= (remaining > BLOCK_W) ? (remaining - BLOCK_W) : 8'd0;
                    end
                end
                ST_DONE: begin
                    if (ack) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy  = (state == ST_COUNT);
    assign valid = (state == ST_DONE);

endmodule
